// File: rtl/la_pwrseq_pkg.sv
// Shared definitions for the la_pwrseq power-domain sequencer: state codes
// and the width helper for the optional level status port (LA_PWRSEQ_STATUS_EN).
package la_pwrseq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_OFF    = 3'd0;
  localparam state_t ST_RAMPUP = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_ON     = 3'd3;
  localparam state_t ST_RAMPDN = 3'd4;

  // Bits needed to hold a segment count from 0 to n inclusive.
  function automatic int level_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/la_pwrseq_timer.sv
// Loadable down-counter shared by the dwell and settle phases of la_pwrseq.
// A load takes priority; otherwise the count decays to zero and holds there.
module la_pwrseq_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          done
);

  logic [CW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/la_pwrseq.sv
// Power-up/down sequencer for a gated domain built from N staggered header
// segments. Optional popcount output 'level' is enabled by LA_PWRSEQ_STATUS_EN.
module la_pwrseq
  import la_pwrseq_pkg::*;
#(
  parameter int    N    = 4,
  parameter int    CW   = 8,
  parameter string PROP = "DEFAULT"
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [CW-1:0] delay,
  output logic [N-1:0]  en,
  output logic          iso,
  output logic          rst_dom,
  output logic          ack,
  output logic          busy
`ifdef LA_PWRSEQ_STATUS_EN
  ,
  output logic [level_width(N)-1:0] level
`endif
);

  state_t       state;
  state_t       state_nx;
  logic [N-1:0] en_nx;
  logic [N-1:0] en_up;
  logic [N-1:0] en_dn;
  logic         iso_nx;
  logic         ack_nx;
  logic         load;
  logic         done;

  la_pwrseq_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .value (delay),
    .done  (done)
  );

  // Thermometer step in either direction; the cast keeps N=1 legal.
  assign en_up = N'({en, 1'b1});
  assign en_dn = en >> 1;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    en_nx    = en;
    iso_nx   = iso;
    ack_nx   = ack;
    load     = 1'b0;
    case (state)
      ST_OFF: begin
        if (req) begin
          en_nx    = N'(1);
          load     = 1'b1;
          state_nx = (N == 1) ? ST_SETTLE : ST_RAMPUP;
        end
      end
      ST_RAMPUP: begin
        if (!req) begin
          state_nx = ST_RAMPDN;
          load     = 1'b1;
        end else if (done) begin
          en_nx = en_up;
          load  = 1'b1;
          if (&en_up) begin
            state_nx = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (!req) begin
          state_nx = ST_RAMPDN;
          load     = 1'b1;
        end else if (done) begin
          state_nx = ST_ON;
          iso_nx   = 1'b0;
          ack_nx   = 1'b1;
        end
      end
      ST_ON: begin
        if (!req) begin
          state_nx = ST_RAMPDN;
          load     = 1'b1;
          iso_nx   = 1'b1;
          ack_nx   = 1'b0;
        end
      end
      ST_RAMPDN: begin
        if (req) begin
          // A fully enabled domain only needs to settle again.
          state_nx = (&en) ? ST_SETTLE : ST_RAMPUP;
          load     = 1'b1;
        end else if (done) begin
          en_nx = en_dn;
          load  = 1'b1;
          if (en_dn == '0) begin
            state_nx = ST_OFF;
          end
        end
      end
      default: begin
        state_nx = ST_OFF;
        en_nx    = '0;
        iso_nx   = 1'b1;
        ack_nx   = 1'b0;
      end
    endcase
  end

  // Reset cuts every segment at once; an abrupt power loss is accepted here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_OFF;
      en      <= '0;
      iso     <= 1'b1;
      rst_dom <= 1'b1;
      ack     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      en      <= en_nx;
      iso     <= iso_nx;
      rst_dom <= iso_nx;
      ack     <= ack_nx;
      busy    <= (state_nx == ST_RAMPUP) || (state_nx == ST_SETTLE) ||
                 (state_nx == ST_RAMPDN);
    end
  end

`ifdef LA_PWRSEQ_STATUS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else begin
      level <= level_width(N)'($countones(en_nx));
    end
  end
`endif

  a_ack_powered : assert property (@(posedge clk) disable iff (reset)
    ack |-> ((&en) && !iso && !rst_dom));
  a_iso_order : assert property (@(posedge clk) disable iff (reset)
    !iso |-> !rst_dom);
  a_thermo : assert property (@(posedge clk) disable iff (reset)
    (en & (en + N'(1))) == '0);

endmodule

// File: tb/tb_la_pwrseq.sv
// Self-checking bench for la_pwrseq: phase-position model plus directed
// scenarios with literal expectations at specific edges.
module tb_la_pwrseq;

  localparam int N  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic [CW-1:0] delay;
  logic [N-1:0]  en;
  logic          iso;
  logic          rst_dom;
  logic          ack;
  logic          busy;
`ifdef LA_PWRSEQ_STATUS_EN
  logic [$clog2(N+1)-1:0] level;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  la_pwrseq #(.N(N), .CW(CW), .PROP("DEFAULT")) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .delay   (delay),
    .en      (en),
    .iso     (iso),
    .rst_dom (rst_dom),
    .ack     (ack),
    .busy    (busy)
`ifdef LA_PWRSEQ_STATUS_EN
    ,
    .level   (level)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position p walks 0..N+1 (p segments on, N+1 = powered and released).
  // It moves one step toward the requested end every D+1 edges, except that
  // leaving either rest end happens on the very edge the request is seen.
  int p   = 0;
  int cnt = 0;
  int dir = 0;

  task automatic model_step(input logic r, input int d);
    int goal;
    int want;
    goal = r ? N + 1 : 0;
    if (p == goal) begin
      // resting
    end else if (p == 0) begin
      p = 1; dir = 1; cnt = d;
    end else if (p == N + 1) begin
      p = N; dir = -1; cnt = d;
    end else begin
      want = (goal > p) ? 1 : -1;
      if (want != dir) begin
        dir = want; cnt = d;
      end else if (cnt != 0) begin
        cnt = cnt - 1;
      end else begin
        p = p + dir; cnt = d;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      p = 0; cnt = 0; dir = 0;
    end else begin
      model_step(req, int'(delay));
    end
  end

  logic [N-1:0] prev_en;
  logic         prev_ok = 1'b0;

  always @(negedge clk) begin
    int lv;
    int step;
    lv = (p > N) ? N : p;
    check("m_en", en, (1 << lv) - 1);
    check("m_iso", iso, p != N + 1);
    check("m_rst_dom", rst_dom, p != N + 1);
    check("m_ack", ack, p == N + 1);
    check("m_busy", busy, (p >= 1) && (p <= N));
`ifdef LA_PWRSEQ_STATUS_EN
    check("m_level", level, lv);
`endif
    check("inv_thermo", en & (en + 4'd1), 0);
    if (ack) check("inv_ack", {en, iso, rst_dom}, {4'b1111, 1'b0, 1'b0});
    if (!iso) check("inv_iso_rst", rst_dom, 0);
    if (prev_ok && !reset) begin
      step = $countones(en) - $countones(prev_en);
      check("inv_step", (step <= 1) && (step >= -1), 1);
    end
    prev_en = en;
    prev_ok = !reset;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    delay = 8'd2;
    #12;
    check("rst_en", en, 0);
    check("rst_iso", iso, 1);
    check("rst_rst_dom", rst_dom, 1);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(2);

    // Power-up, D=2
    req = 1'b1;
    tick(1);
    check("up_T0_en", en, 4'b0001);
    check("up_T0_busy", busy, 1);
`ifdef LA_PWRSEQ_STATUS_EN
    check("up_T0_level", level, 1);
`endif
    tick(2); check("up_T2_en", en, 4'b0001);
    tick(1); check("up_T3_en", en, 4'b0011);
`ifdef LA_PWRSEQ_STATUS_EN
    check("up_T3_level", level, 2);
`endif
    tick(3); check("up_T6_en", en, 4'b0111);
`ifdef LA_PWRSEQ_STATUS_EN
    check("up_T6_level", level, 3);
`endif
    tick(3); check("up_T9_en", en, 4'b1111);
`ifdef LA_PWRSEQ_STATUS_EN
    check("up_T9_level", level, 4);
`endif
    tick(2);
    check("up_T11_busy", busy, 1);
    check("up_T11_ack", ack, 0);
    tick(1);
    check("up_T12_ack", ack, 1);
    check("up_T12_iso", iso, 0);
    check("up_T12_rst", rst_dom, 0);
    check("up_T12_busy", busy, 0);
    tick(3);

    // Power-down, D=2
    req = 1'b0;
    tick(1);
    check("dn_T1_iso", iso, 1);
    check("dn_T1_rst", rst_dom, 1);
    check("dn_T1_ack", ack, 0);
    check("dn_T1_en", en, 4'b1111);
    tick(3); check("dn_T3_en", en, 4'b0111);
    tick(3); check("dn_T6_en", en, 4'b0011);
    tick(3); check("dn_T9_en", en, 4'b0001);
    tick(3);
    check("dn_T12_en", en, 0);
    check("dn_T12_busy", busy, 0);
    tick(2);

    // D=0: one segment per cycle
    delay = 8'd0;
    req   = 1'b1;
    tick(1); check("d0_T0_en", en, 4'b0001);
    tick(3);
    check("d0_T3_en", en, 4'b1111);
    check("d0_T3_ack", ack, 0);
    tick(1); check("d0_T4_ack", ack, 1);
    tick(2);
    req = 1'b0;
    tick(1);
    tick(3); check("d0_dn_T3_en", en, 4'b0001);
    tick(1);
    check("d0_dn_T4_en", en, 0);
    check("d0_dn_T4_busy", busy, 0);
    tick(2);

    // Reversal during ramp-up, left to finish powering down
    delay = 8'd2;
    req   = 1'b1;
    tick(1);
    tick(3); check("rv_T3_en", en, 4'b0011);
    req = 1'b0;
    tick(1);
    check("rv_T4_iso", iso, 1);
    check("rv_T4_rst", rst_dom, 1);
    check("rv_T4_en", en, 4'b0011);
    tick(3); check("rv_T7_en", en, 4'b0001);
    tick(3);
    check("rv_T10_en", en, 0);
    check("rv_T10_busy", busy, 0);
    tick(2);

    // Reversal down then up again
    req = 1'b1;
    tick(1);
    tick(3);
    req = 1'b0;
    tick(4); check("rr_T7_en", en, 4'b0001);
    req = 1'b1;
    tick(1);
    tick(3);
    check("rr_T11_en", en, 4'b0011);
    check("rr_T11_iso", iso, 1);
    tick(10); check("rr_T21_ack", ack, 1);

    // From ON, drop then immediately re-raise with en full: settle again
    req = 1'b0;
    tick(1);
    req = 1'b1;
    tick(1);
    check("fs_busy", busy, 1);
    check("fs_ack", ack, 0);
    check("fs_en", en, 4'b1111);
    tick(3); check("fs_ack_back", ack, 1);

    // Delay change mid-dwell takes effect at the next reload only
    delay = 8'd1;
    req   = 1'b0;
    tick(1);
    tick(1);
    delay = 8'd3;
    tick(1); check("dc_T2_en", en, 4'b0111);
    tick(3); check("dc_T5_en", en, 4'b0111);
    tick(1); check("dc_T6_en", en, 4'b0011);
    tick(8);
    check("dc_T14_en", en, 0);
    check("dc_T14_busy", busy, 0);
    tick(2);

    // Asynchronous reset while settling, then restart
    delay = 8'd2;
    req   = 1'b1;
    tick(1);
    tick(10);
    check("ar_settle_busy", busy, 1);
    check("ar_settle_en", en, 4'b1111);
    #2 reset = 1'b1;
    #1;
    check("ar_en", en, 0);
    check("ar_iso", iso, 1);
    check("ar_rst", rst_dom, 1);
    check("ar_ack", ack, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(1);
    check("ar_restart_en", en, 4'b0001);
    check("ar_restart_busy", busy, 1);
    tick(12); check("ar_restart_ack", ack, 1);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/la_pwrseq.md
Name: la_pwrseq

Overview:
- Power-up/power-down sequencer for a gated power domain built from N staggered power-switch (header) segments, with the domain's decap cells as the charge reservoir.
- Enables switch segments one at a time with a programmable dwell, which limits inrush current and supply droop.
- Then waits a settle interval, releases domain reset and isolation, and acknowledges; power-down reverses the sequence.
- Sits in the always-on domain next to the auxlib power-switch and decap instances.

Parameters:
- N, 4, number of power-switch segments (≥1)
- CW, 8, width of dwell/settle delay counter
- PROP, "DEFAULT", implementation property string passed through for cell selection

Ports:
- clk  input  1  sequencer clock (always-on)
- reset  input  1  asynchronous active-high reset
- req  input  1  level request: 1 = domain on, 0 = domain off
- delay  input  CW  dwell D; each step lasts D+1 cycles; sampled at every counter reload
- en  output  N  switch-segment enables, thermometer coded from bit 0
- iso  output  1  isolation enable, active-high
- rst_dom  output  1  domain reset, active-high
- ack  output  1  domain powered, isolation released
- busy  output  1  sequence in progress

Behaviour:
- Reset values (asynchronous): state OFF, en=0, iso=1, rst_dom=1, ack=0, busy=0, cnt=0.
- Reset asserted mid-sequence drops all enables immediately; this abrupt cut is accepted and documented.
- States: OFF, RAMPUP, SETTLE, ON, RAMPDN.
- busy=1 in RAMPUP, SETTLE and RAMPDN.
- OFF:
  - req=1 sampled at edge T0 → RAMPUP.
  - At that same edge: en[0]=1, cnt=D.
- RAMPUP:
  - cnt≠0 → cnt-1.
  - cnt==0 and en not full → en={en[N-2:0],1}, cnt=D.
  - Result: en[k] rises at T0+k·(D+1).
  - The edge that sets en[N-1] also moves to SETTLE and reloads cnt=D.
  - N=1: OFF goes directly to SETTLE with en=1.
- SETTLE:
  - Counts down.
  - cnt==0 → iso=0, rst_dom=0, ack=1, state ON, all at the same edge.
  - ack therefore rises at T0+N·(D+1).
- ON: holds; outputs are stable.
- ON and req=0 sampled at edge T1:
  - iso=1, rst_dom=1, ack=0, state RAMPDN, cnt=D, all at that edge.
- RAMPDN:
  - cnt==0 → en=en>>1 (highest segment drops first), cnt=D.
  - When en becomes 0 → OFF, busy=0.
  - Segment N-1 falls at T1+(D+1); all off at T1+N·(D+1).
- Reversal:
  - RAMPUP or SETTLE with req=0 → RAMPDN with cnt=D. en is kept; iso and rst_dom stay 1.
  - RAMPDN with req=1 → RAMPUP with cnt=D. en is kept; the next segment rises after D+1 cycles.
  - If en is already full, go to SETTLE instead.
- D=0: one segment per cycle.
- delay changes take effect at the next reload only.
- Invariants:
  - ack=1 implies en all ones, iso=0, rst_dom=0.
  - iso=0 implies rst_dom=0.
  - en is always thermometer coded.
  - en never changes by more than one bit per cycle.

Optional Feature:
- Macro: LA_PWRSEQ_STATUS_EN.
- Defined: adds output port level, width $clog2(N+1), equal to the popcount of en; it is registered with en and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package la_pwrseq_pkg:
  - state enum (OFF, RAMPUP, SETTLE, ON, RAMPDN), 3-bit encoding
  - function for the level-width calculation
- Sub-module la_pwrseq_timer:
  - CW-bit loadable down-counter
  - inputs load and value; output done = (cnt==0)
  - reused for dwell and settle
- The FSM and en shifter live in la_pwrseq.

Test Plan:
- N=4, D=2, req 0→1 at edge T0 → en=0001@T0, 0011@T0+3, 0111@T0+6, 1111@T0+9; ack=1, iso=0, rst_dom=0 @T0+12; busy=1 from T0 to T0+11.
- From ON, req 1→0 at T1 (D=2) → iso=1, rst_dom=1, ack=0 @T1; en=0111@T1+3, 0011@T1+6, 0001@T1+9, 0000@T1+12 with busy=0, state OFF.
- D=0, N=4 → one enable bit per cycle, 1111 at T0+3, ack at T0+4; power-down all off at T1+4.
- Reversal: req drops at T0+4 (en=0011) → iso/rst_dom stay 1, en=0001 at T0+7, 0000 at T0+10; re-raising req at T0+8 → en=0011 at T0+11.
- Reset asserted in SETTLE, asynchronous mid-cycle → en=0, iso=1, rst_dom=1, ack=0 immediately without waiting for a clock; after release with req=1, the sequence restarts from OFF.
- With LA_PWRSEQ_STATUS_EN defined → level tracks 0,1,2,3,4 alongside en in the first scenario; the assertion checker runs in all tests (thermometer code, single-bit step, ack/iso/rst invariants).
